// File: rtl/beta_mem_arbiter.sv
// beta_mem_arbiter: round-robin sharing of one memory port between
// instruction fetch, data load and data store, one transaction in flight,
// with a response timeout that closes the transaction and flags err_o.
module beta_mem_arbiter #(
  parameter int DataWidth     = 32,
  parameter int AddressWidth  = 32,
  parameter int TimeoutCycles = 255
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  // fetch requester
  input  logic                      instr_req_i,
  input  logic [AddressWidth-1:0]   instr_addr_i,
  output logic                      instr_ready_o,
  output logic                      instr_valid_o,
  output logic [DataWidth-1:0]      instr_rdata_o,
  // load requester
  input  logic                      rdata_req_i,
  input  logic [AddressWidth-1:0]   rdata_addr_i,
  input  logic [DataWidth/8-1:0]    rdata_strb_i,
  output logic                      rdata_ready_o,
  output logic                      rdata_valid_o,
  output logic [DataWidth-1:0]      rdata_data_o,
  // store requester
  input  logic                      wdata_req_i,
  input  logic [AddressWidth-1:0]   wdata_addr_i,
  input  logic [DataWidth-1:0]      wdata_data_i,
  input  logic [DataWidth/8-1:0]    wdata_strb_i,
  output logic                      wdata_ready_o,
  output logic                      wdata_valid_o,
  // memory side
  output logic                      mem_req_o,
  output logic                      mem_we_o,
  output logic [AddressWidth-1:0]   mem_addr_o,
  output logic [DataWidth-1:0]      mem_wdata_o,
  output logic [DataWidth/8-1:0]    mem_strb_o,
  input  logic                      mem_ready_i,
  input  logic                      mem_valid_i,
  input  logic [DataWidth-1:0]      mem_rdata_i,
  // status
  output logic [1:0]                grant_o,
  output logic                      busy_o,
  output logic                      err_o
);

  localparam int StrbWidth = DataWidth / 8;
  localparam int CntWidth  = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  localparam bit TimeoutEn = (TimeoutCycles > 0);
  localparam logic [CntWidth-1:0] CntLast =
      (TimeoutCycles > 0) ? CntWidth'(TimeoutCycles - 1) : '0;

  localparam logic [1:0] OwnInstr = 2'd0;
  localparam logic [1:0] OwnRead  = 2'd1;
  localparam logic [1:0] OwnWrite = 2'd2;
  localparam logic [1:0] OwnNone  = 2'd3;

  typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, RESP = 2'd2} state_t;

  state_t                  state_reg, state_next;
  logic [1:0]              owner_reg, last_grant_reg;
  logic [AddressWidth-1:0] addr_reg;
  logic                    we_reg;
  logic [DataWidth-1:0]    wdata_reg;
  logic [StrbWidth-1:0]    strb_reg;
  logic [CntWidth-1:0]     cnt_reg;

  logic [2:0]              req_vec, owner_hit, ready_vec, valid_vec;
  logic [1:0]              cand1, cand2, cand3, win_idx;
  logic                    accept, mem_done, timeout_hit;
  logic [DataWidth-1:0]    resp_data;

  function automatic logic [1:0] next_idx(input logic [1:0] idx);
    return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

  assign req_vec = {wdata_req_i, rdata_req_i, instr_req_i};
  assign cand1   = next_idx(last_grant_reg);
  assign cand2   = next_idx(cand1);
  assign cand3   = next_idx(cand2);

  // One-hot owner decode, one lane per requester.
  for (genvar gi = 0; gi < 3; gi++) begin : g_owner
    assign owner_hit[gi] = (owner_reg == 2'(gi));
  end

  // Round-robin pick: scan requesters starting just after the last owner.
  always_comb begin
    win_idx = cand3;
    if (req_vec[cand1])      win_idx = cand1;
    else if (req_vec[cand2]) win_idx = cand2;
  end

  assign accept      = (state_reg == ADDR) && mem_ready_i;
  assign mem_done    = ((state_reg == ADDR) && mem_ready_i && mem_valid_i) ||
                       ((state_reg == RESP) && mem_valid_i);
  assign timeout_hit = TimeoutEn && (state_reg == RESP) && !mem_valid_i &&
                       (cnt_reg == CntLast);

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic: sample in IDLE, wait for accept in ADDR, wait for response in RESP.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (|req_vec) state_next = ADDR;
      ADDR:    if (mem_ready_i) state_next = mem_valid_i ? IDLE : RESP;
      RESP:    if (mem_valid_i || timeout_hit) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Latched transaction fields, round-robin history and the response timer.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      owner_reg      <= OwnInstr;
      last_grant_reg <= OwnWrite;
      addr_reg       <= '0;
      we_reg         <= 1'b0;
      wdata_reg      <= '0;
      strb_reg       <= '0;
      cnt_reg        <= '0;
    end else begin
      if ((state_reg == IDLE) && (|req_vec)) begin
        owner_reg <= win_idx;
        we_reg    <= (win_idx == OwnWrite);
        case (win_idx)
          OwnInstr: begin addr_reg <= instr_addr_i; wdata_reg <= '0; strb_reg <= '1; end
          OwnRead:  begin addr_reg <= rdata_addr_i; wdata_reg <= '0; strb_reg <= rdata_strb_i; end
          default:  begin addr_reg <= wdata_addr_i; wdata_reg <= wdata_data_i; strb_reg <= wdata_strb_i; end
        endcase
      end
      if (state_reg == RESP)
        cnt_reg <= (mem_valid_i || timeout_hit) ? '0 : cnt_reg + 1'b1;
      if (mem_done || timeout_hit)
        last_grant_reg <= owner_reg;
    end
  end

  // Outputs: memory request from latched fields, per-owner handshake pulses.
  // Pulses are suppressed while reset is asserted so an in-flight response is dropped.
  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_strb_o  = '0;
    grant_o     = OwnNone;
    busy_o      = 1'b0;
    err_o       = 1'b0;
    ready_vec   = '0;
    valid_vec   = '0;
    resp_data   = '0;
    if (state_reg == ADDR) begin
      mem_req_o   = 1'b1;
      mem_we_o    = we_reg;
      mem_addr_o  = addr_reg;
      mem_wdata_o = wdata_reg;
      mem_strb_o  = strb_reg;
    end
    if (state_reg != IDLE) begin
      grant_o = owner_reg;
      busy_o  = 1'b1;
    end
    if (!rst_i) begin
      if (accept)                  ready_vec = owner_hit;
      if (mem_done || timeout_hit) valid_vec = owner_hit;
      if (mem_done)                resp_data = mem_rdata_i;
      err_o = timeout_hit;
    end
  end

  assign instr_ready_o = ready_vec[0];
  assign rdata_ready_o = ready_vec[1];
  assign wdata_ready_o = ready_vec[2];
  assign instr_valid_o = valid_vec[0];
  assign rdata_valid_o = valid_vec[1];
  assign wdata_valid_o = valid_vec[2];
  assign instr_rdata_o = valid_vec[0] ? resp_data : '0;
  assign rdata_data_o  = valid_vec[1] ? resp_data : '0;

endmodule

// File: tb/tb_beta_mem_arbiter.sv
// Testbench for beta_mem_arbiter: transaction-level reference model checked
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_beta_mem_arbiter;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          instr_req_i, instr_ready_o, instr_valid_o;
  logic [AW-1:0] instr_addr_i;
  logic [DW-1:0] instr_rdata_o;
  logic          rdata_req_i, rdata_ready_o, rdata_valid_o;
  logic [AW-1:0] rdata_addr_i;
  logic [3:0]    rdata_strb_i;
  logic [DW-1:0] rdata_data_o;
  logic          wdata_req_i, wdata_ready_o, wdata_valid_o;
  logic [AW-1:0] wdata_addr_i;
  logic [DW-1:0] wdata_data_i;
  logic [3:0]    wdata_strb_i;
  logic          mem_req_o, mem_we_o, mem_ready_i, mem_valid_i;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o, mem_rdata_i;
  logic [3:0]    mem_strb_o;
  logic [1:0]    grant_o;
  logic          busy_o, err_o;

  always #5 clk = ~clk;

  beta_mem_arbiter #(.DataWidth(DW), .AddressWidth(AW), .TimeoutCycles(TO)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_ready_o(instr_ready_o),
    .instr_valid_o(instr_valid_o), .instr_rdata_o(instr_rdata_o),
    .rdata_req_i(rdata_req_i), .rdata_addr_i(rdata_addr_i), .rdata_strb_i(rdata_strb_i),
    .rdata_ready_o(rdata_ready_o), .rdata_valid_o(rdata_valid_o), .rdata_data_o(rdata_data_o),
    .wdata_req_i(wdata_req_i), .wdata_addr_i(wdata_addr_i), .wdata_data_i(wdata_data_i),
    .wdata_strb_i(wdata_strb_i), .wdata_ready_o(wdata_ready_o), .wdata_valid_o(wdata_valid_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_strb_o(mem_strb_o),
    .mem_ready_i(mem_ready_i), .mem_valid_i(mem_valid_i), .mem_rdata_i(mem_rdata_i),
    .grant_o(grant_o), .busy_o(busy_o), .err_o(err_o)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Reference model: one pending transaction, its owner, whether memory took it,
  // and how many response cycles have elapsed.
  bit          m_busy = 1'b0;
  bit          m_acc  = 1'b0;
  int          m_owner = 0;
  int          m_last  = 2;
  int          m_wait  = 0;
  logic [31:0] m_addr = '0, m_wdata = '0;
  logic [3:0]  m_strb = '0;

  // Per-cycle expectations.
  logic [2:0]  reqv, e_rdy, e_vld, a_rdy, a_vld;
  logic        e_req, e_busy, e_err, fin;
  logic [1:0]  e_grant;
  logic [31:0] e_idata, e_rdata, vdat;

  // Observed statistics for the directed scenarios.
  int          n_memreq, n_err, err_cyc, acc_cyc;
  int          n_rdy[3], n_vld[3], rdy_cyc[3], vld_cyc[3];
  logic [31:0] vdata[3];
  logic [31:0] cap_addr, cap_wdata;
  logic        cap_we;
  logic [3:0]  cap_strb;
  int          grant_q[$];
  int          gcyc_q[$];
  bit          prev_req = 1'b0, acc_seen = 1'b0;
  bit          rdy_seen[3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, act, exp);
    end
  endtask

  task automatic clr_stats();
    n_memreq = 0; n_err = 0; err_cyc = -1; acc_cyc = -1;
    for (int i = 0; i < 3; i++) begin
      n_rdy[i] = 0; n_vld[i] = 0; rdy_cyc[i] = -1; vld_cyc[i] = -1; vdata[i] = 'x;
    end
    grant_q.delete(); gcyc_q.delete();
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    instr_req_i = 0; instr_addr_i = '0;
    rdata_req_i = 0; rdata_addr_i = '0; rdata_strb_i = '0;
    wdata_req_i = 0; wdata_addr_i = '0; wdata_data_i = '0; wdata_strb_i = '0;
    mem_ready_i = 0; mem_valid_i = 0; mem_rdata_i = '0;
  endtask

  task automatic do_reset();
    rst_i = 1; tick(); rst_i = 0;
  endtask

  // Compare process: check DUT against the model, collect stats, advance the model.
  always @(negedge clk) begin
    cyc++;
    if (rst_i) begin
      m_busy = 0; m_acc = 0; m_last = 2; m_wait = 0;
      prev_req = 0; acc_seen = 0;
      for (int i = 0; i < 3; i++) rdy_seen[i] = 0;
    end else begin
      reqv = {wdata_req_i, rdata_req_i, instr_req_i};
      e_req = 0; e_grant = 2'd3; e_busy = 0; e_err = 0; e_rdy = '0; e_vld = '0;
      e_idata = '0; e_rdata = '0; fin = 0; vdat = '0;
      if (m_busy) begin
        e_grant = 2'(m_owner); e_busy = 1;
        if (!m_acc) begin
          e_req = 1;
          if (mem_ready_i) begin
            e_rdy[m_owner] = 1;
            if (mem_valid_i) begin fin = 1; vdat = mem_rdata_i; end
          end
        end else if (mem_valid_i) begin
          fin = 1; vdat = mem_rdata_i;
        end else if (m_wait == TO - 1) begin
          fin = 1; e_err = 1; vdat = '0;
        end
        if (fin) begin
          e_vld[m_owner] = 1;
          if (m_owner == 0) e_idata = vdat;
          if (m_owner == 1) e_rdata = vdat;
        end
      end
      a_rdy = {wdata_ready_o, rdata_ready_o, instr_ready_o};
      a_vld = {wdata_valid_o, rdata_valid_o, instr_valid_o};
      chk("mem_req", 32'(mem_req_o), 32'(e_req));
      chk("grant", 32'(grant_o), 32'(e_grant));
      chk("busy", 32'(busy_o), 32'(e_busy));
      chk("err", 32'(err_o), 32'(e_err));
      chk("ready_vec", 32'(a_rdy), 32'(e_rdy));
      chk("valid_vec", 32'(a_vld), 32'(e_vld));
      chk("instr_rdata", instr_rdata_o, e_idata);
      chk("rdata_data", rdata_data_o, e_rdata);
      if (e_req) begin
        chk("mem_addr", mem_addr_o, m_addr);
        chk("mem_we", 32'(mem_we_o), (m_owner == 2) ? 32'd1 : 32'd0);
        chk("mem_wdata", mem_wdata_o, (m_owner == 2) ? m_wdata : 32'd0);
        chk("mem_strb", 32'(mem_strb_o), 32'(m_strb));
      end

      if (mem_req_o) n_memreq++;
      if (mem_req_o && !prev_req) begin
        grant_q.push_back(int'(grant_o)); gcyc_q.push_back(cyc);
        cap_addr = mem_addr_o; cap_wdata = mem_wdata_o; cap_we = mem_we_o; cap_strb = mem_strb_o;
      end
      prev_req = mem_req_o;
      if (mem_req_o && mem_ready_i) acc_cyc = cyc;
      acc_seen = mem_req_o && mem_ready_i;
      for (int i = 0; i < 3; i++) begin
        rdy_seen[i] = a_rdy[i];
        if (a_rdy[i]) begin n_rdy[i]++; rdy_cyc[i] = cyc; end
        if (a_vld[i]) begin
          n_vld[i]++; vld_cyc[i] = cyc;
          vdata[i] = (i == 0) ? instr_rdata_o : (i == 1) ? rdata_data_o : 32'd0;
        end
      end
      if (err_o) begin n_err++; err_cyc = cyc; end

      if (m_busy) begin
        if (fin) begin
          m_busy = 0; m_last = m_owner;
          $display("[TB] txn cyc=%0d owner=%0d addr=%h data=%h%s",
                   cyc, m_owner, m_addr, vdat, e_err ? " timeout" : "");
        end else if (!m_acc) begin
          if (mem_ready_i) begin m_acc = 1; m_wait = 0; end
        end else begin
          m_wait++;
        end
      end else if (reqv != 3'b000) begin
        for (int k = 1; k <= 3; k++) begin
          if (!m_busy && reqv[(m_last + k) % 3]) begin
            m_busy = 1; m_acc = 0; m_owner = (m_last + k) % 3;
          end
        end
        m_addr  = (m_owner == 0) ? instr_addr_i : (m_owner == 1) ? rdata_addr_i : wdata_addr_i;
        m_strb  = (m_owner == 0) ? 4'hF : (m_owner == 1) ? rdata_strb_i : wdata_strb_i;
        m_wdata = wdata_data_i;
      end
    end
  end

  task automatic rand_cycle();
    if (!instr_req_i || rdy_seen[0]) begin
      instr_req_i = instr_req_i ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 2) == 0);
      instr_addr_i = $urandom;
    end
    if (!rdata_req_i || rdy_seen[1]) begin
      rdata_req_i = rdata_req_i ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 2) == 0);
      rdata_addr_i = $urandom; rdata_strb_i = 4'($urandom);
    end
    if (!wdata_req_i || rdy_seen[2]) begin
      wdata_req_i = wdata_req_i ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 2) == 0);
      wdata_addr_i = $urandom; wdata_data_i = $urandom; wdata_strb_i = 4'($urandom);
    end
    mem_ready_i = ($urandom_range(0, 2) == 0);
    mem_valid_i = ($urandom_range(0, 3) == 0);
    mem_rdata_i = $urandom;
    rst_i = ($urandom_range(0, 299) == 0);
  endtask

  initial begin
    idle_inputs();
    clr_stats();
    rst_i = 1;
    repeat (3) @(posedge clk);
    #1 rst_i = 0;

    // Reset state.
    @(negedge clk);
    chk("rst_mem_req", 32'(mem_req_o), 32'd0);
    chk("rst_mem_addr", mem_addr_o, 32'd0);
    chk("rst_mem_we", 32'(mem_we_o), 32'd0);
    chk("rst_mem_strb", 32'(mem_strb_o), 32'd0);
    chk("rst_grant", 32'(grant_o), 32'd3);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_valids", 32'({instr_valid_o, rdata_valid_o, wdata_valid_o}), 32'd0);
    chk("rst_readys", 32'({instr_ready_o, rdata_ready_o, wdata_ready_o}), 32'd0);

    // Fetch with two-cycle accept and one-cycle response.
    tick(); clr_stats();
    instr_req_i = 1; instr_addr_i = 32'h100;
    tick();
    tick(); mem_ready_i = 1;
    tick(); instr_req_i = 0; mem_ready_i = 0; mem_valid_i = 1; mem_rdata_i = 32'hDEADBEEF;
    tick(); mem_valid_i = 0; mem_rdata_i = '0;
    tick(); tick();
    chk("f_memreq_cycles", n_memreq, 2);
    chk("f_addr", cap_addr, 32'h100);
    chk("f_strb", 32'(cap_strb), 32'hF);
    chk("f_we", 32'(cap_we), 32'd0);
    chk("f_ready_cnt", n_rdy[0], 1);
    chk("f_valid_cnt", n_vld[0], 1);
    chk("f_data", vdata[0], 32'hDEADBEEF);

    // All three requesting continuously, accept immediately, respond next cycle.
    do_reset(); clr_stats();
    instr_req_i = 1; instr_addr_i = 32'h1000;
    rdata_req_i = 1; rdata_addr_i = 32'h2000; rdata_strb_i = 4'hF;
    wdata_req_i = 1; wdata_addr_i = 32'h3000; wdata_data_i = 32'h5A5A5A5A; wdata_strb_i = 4'hF;
    mem_ready_i = 1;
    repeat (24) begin tick(); mem_valid_i = acc_seen; end
    chk("rr_count_ok", 32'(grant_q.size() >= 6), 32'd1);
    for (int i = 0; i < 6; i++) begin
      if (i < grant_q.size()) begin
        chk("rr_grant", grant_q[i], i % 3);
        if (i > 0) chk("rr_gap", gcyc_q[i] - gcyc_q[i-1], 3);
      end
    end
    instr_req_i = 0; rdata_req_i = 0; wdata_req_i = 0;
    repeat (5) begin tick(); mem_valid_i = acc_seen; end
    idle_inputs(); tick();

    // Store with exact payload.
    clr_stats();
    wdata_req_i = 1; wdata_addr_i = 32'h2004; wdata_data_i = 32'h12345678; wdata_strb_i = 4'h3;
    tick(); mem_ready_i = 1;
    tick(); wdata_req_i = 0; mem_ready_i = 0;
    tick(); mem_valid_i = 1; mem_rdata_i = 32'hCAFEF00D;
    tick(); mem_valid_i = 0;
    tick(); tick();
    chk("st_we", 32'(cap_we), 32'd1);
    chk("st_addr", cap_addr, 32'h2004);
    chk("st_wdata", cap_wdata, 32'h12345678);
    chk("st_strb", 32'(cap_strb), 32'h3);
    chk("st_wvalid", n_vld[2], 1);
    chk("st_rvalid", n_vld[1], 0);
    chk("st_ivalid", n_vld[0], 0);

    // Load accepted and answered in the same cycle.
    clr_stats();
    rdata_req_i = 1; rdata_addr_i = 32'h40; rdata_strb_i = 4'hF;
    mem_ready_i = 1; mem_valid_i = 1; mem_rdata_i = 32'h0BADF00D;
    tick();
    tick(); rdata_req_i = 0; mem_ready_i = 0; mem_valid_i = 0;
    @(negedge clk);
    chk("ld_busy_after", 32'(busy_o), 32'd0);
    tick();
    chk("ld_ready", n_rdy[1], 1);
    chk("ld_valid", n_vld[1], 1);
    chk("ld_same_cycle", rdy_cyc[1], vld_cyc[1]);
    chk("ld_data", vdata[1], 32'h0BADF00D);

    // Accepted fetch that never gets a response.
    clr_stats();
    instr_req_i = 1; instr_addr_i = 32'h300;
    tick(); mem_ready_i = 1;
    tick(); instr_req_i = 0; mem_ready_i = 0;
    tick(); tick(); tick();
    tick(); mem_valid_i = 1; mem_rdata_i = 32'h99999999;
    tick();
    tick(); mem_valid_i = 0;
    tick();
    chk("to_err_cnt", n_err, 1);
    chk("to_err_delay", err_cyc - acc_cyc, 4);
    chk("to_valid_cnt", n_vld[0] + n_vld[1] + n_vld[2], 1);
    chk("to_valid_cyc", vld_cyc[0], err_cyc);
    chk("to_data", vdata[0], 32'd0);

    // Reset during a pending store response, then a late response.
    rdata_req_i = 1; rdata_addr_i = 32'h44; rdata_strb_i = 4'hC;
    mem_ready_i = 1; mem_valid_i = 1; mem_rdata_i = 32'h11111111;
    tick();
    tick(); rdata_req_i = 0; mem_ready_i = 0; mem_valid_i = 0;
    tick();
    wdata_req_i = 1; wdata_addr_i = 32'h500; wdata_data_i = 32'hAA55AA55; wdata_strb_i = 4'hF;
    tick(); mem_ready_i = 1;
    tick(); wdata_req_i = 0; mem_ready_i = 0;
    tick(); rst_i = 1;
    tick(); rst_i = 0; mem_valid_i = 1; mem_rdata_i = 32'h77777777; clr_stats();
    @(negedge clk);
    chk("rr_rst_grant", 32'(grant_o), 32'd3);
    chk("rr_rst_busy", 32'(busy_o), 32'd0);
    chk("rr_rst_wvalid", 32'(wdata_valid_o), 32'd0);
    chk("rr_rst_memreq", 32'(mem_req_o), 32'd0);
    tick();
    tick(); mem_valid_i = 0;
    tick();
    chk("rst_no_valid", n_vld[0] + n_vld[1] + n_vld[2], 0);
    clr_stats();
    instr_req_i = 1; instr_addr_i = 32'h600;
    rdata_req_i = 1; rdata_addr_i = 32'h700; rdata_strb_i = 4'h1;
    wdata_req_i = 1; wdata_addr_i = 32'h800; wdata_data_i = 32'h01020304; wdata_strb_i = 4'h8;
    tick(); tick();
    chk("post_rst_has_grant", 32'(grant_q.size() > 0), 32'd1);
    if (grant_q.size() > 0) chk("post_rst_first", grant_q[0], 0);

    // Random traffic against the model.
    repeat (3000) begin
      rand_cycle();
      tick();
    end
    rst_i = 0;
    idle_inputs();
    repeat (10) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
